zint_ctrl: RTL and testbench

Parametrised interrupt controller for the ZX-bus network/USB card, generalising the fixed two-source, level-only interrupt combiner into NCH channels. Each channel has a synchroniser, a per-channel polarity, edge or level mode, a pending bit, an enable mask and a priority encoder. The block drives an active-high request that the top level turns into the open-drain `zint_n`. It also offers an optional fixed-width pulse mode for hosts that must not see INT held low.

---
 rtl/zint_pkg.sv | 26 ++
 rtl/zint_sync.sv | 40 ++++
 rtl/zint_ctrl.sv | 163 ++++++++++++++++
 tb/tb_zint_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/zint_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zint_pkg
//  Description : Register map, FSM state encoding and CTRL bit positions for
//                the ZX-bus interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package zint_pkg;

    localparam logic [1:0] ZINT_ENA  = 2'd0;
    localparam logic [1:0] ZINT_MODE = 2'd1;
    localparam logic [1:0] ZINT_PEND = 2'd2;
    localparam logic [1:0] ZINT_CTRL = 2'd3;

    typedef logic [1:0] zint_state_t;
    localparam zint_state_t ST_IDLE   = 2'd0;
    localparam zint_state_t ST_ASSERT = 2'd1;
    localparam zint_state_t ST_WAIT   = 2'd2;

    localparam int CTRL_GEN_BIT = 0;
    localparam int CTRL_IDX_LSB = 4;
    localparam int CTRL_IDX_MSB = 6;
    localparam int CTRL_INT_BIT = 7;

endpackage
`default_nettype wire

// File: rtl/zint_sync.sv
`default_nettype none
// ============================================================================
//  Module      : zint_sync
//  Description : Per-channel polarity normalise, synchroniser chain and
//                rising-edge detect on the synchronised active level.
//  Revision    : 1.0 - initial release
// ============================================================================
module zint_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit POL         = 1'b1
) (
    input  logic fclk,
    input  logic rst,
    input  logic irq_raw,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;
    logic                   w_norm;

    // Normalised so that 1 always means "active", whatever the pin polarity.
    assign w_norm = irq_raw ^ ~POL;

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], w_norm};
            r_prev  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign s    = r_chain[SYNC_STAGES-1];
    assign rise = s & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/zint_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : zint_ctrl
//  Description : NCH-channel interrupt controller with edge/level pending
//                bits, enable mask, priority encoder and level or pulse output.
//  Revision    : 1.0 - initial release
// ============================================================================
module zint_ctrl
    import zint_pkg::*;
#(
    parameter int         NCH         = 4,
    parameter logic [7:0] IRQ_POL     = 8'h00,
    parameter int         SYNC_STAGES = 2,
    parameter int         PULSE_LEN   = 0
) (
    input  logic           fclk,
    input  logic           rst,
    input  logic [NCH-1:0] irq_raw,
    input  logic           wr_en,
    input  logic [1:0]     addr,
    input  logic [7:0]     wrdata,
    output logic [7:0]     rddata,
    output logic           internal_int,
    output logic           zint_req
);

    logic [NCH-1:0] r_ena;
    logic [NCH-1:0] r_mode;
    logic [NCH-1:0] r_pend;
    logic           r_gen;

    logic [NCH-1:0] w_s;
    logic [NCH-1:0] w_rise;
    logic [NCH-1:0] w_clr;
    logic [NCH-1:0] w_pend_nxt;
    logic [NCH-1:0] w_masked;
    logic           w_any;
    logic [2:0]     w_idx;
    logic           w_unused;

    assign w_unused = ^wrdata;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        zint_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .POL         (IRQ_POL[i])
        ) u_sync (
            .fclk    (fclk),
            .rst     (rst),
            .irq_raw (irq_raw[i]),
            .s       (w_s[i]),
            .rise    (w_rise[i])
        );
    end

    assign w_clr = (wr_en && addr == ZINT_PEND) ? wrdata[NCH-1:0] : '0;

    // Edge channels: set beats a simultaneous write-1 clear. Level channels track s.
    assign w_pend_nxt = (r_mode & (w_rise | (r_pend & ~w_clr))) | (~r_mode & w_s);

    assign w_masked = r_pend & r_ena;
    assign w_any    = |w_masked;

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_ena        <= '0;
            r_mode       <= '0;
            r_pend       <= '0;
            r_gen        <= 1'b0;
            internal_int <= 1'b0;
        end else begin
            if (wr_en && addr == ZINT_ENA)  r_ena  <= wrdata[NCH-1:0];
            if (wr_en && addr == ZINT_MODE) r_mode <= wrdata[NCH-1:0];
            if (wr_en && addr == ZINT_CTRL) r_gen  <= wrdata[CTRL_GEN_BIT];
            r_pend       <= w_pend_nxt;
            internal_int <= w_any;
        end
    end

    // Descending scan so the lowest-index hit is the last one written.
    always_comb begin
        w_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_masked[i]) w_idx = 3'(i);
        end
    end

    always_comb begin
        rddata = '0;
        case (addr)
            ZINT_ENA:  rddata[NCH-1:0] = r_ena;
            ZINT_MODE: rddata[NCH-1:0] = r_mode;
            ZINT_PEND: rddata[NCH-1:0] = r_pend;
            default: begin
                rddata[CTRL_GEN_BIT]              = r_gen;
                rddata[CTRL_IDX_MSB:CTRL_IDX_LSB] = w_idx;
                rddata[CTRL_INT_BIT]              = internal_int;
            end
        endcase
    end

    if (PULSE_LEN == 0) begin : g_level
        always_ff @(posedge fclk or posedge rst) begin
            if (rst) zint_req <= 1'b0;
            else     zint_req <= r_gen & w_any;
        end
    end else begin : g_pulse
        localparam logic [7:0] c_LOAD = 8'(PULSE_LEN - 1);

        zint_state_t r_state;
        logic [7:0]  r_cnt;
        logic        w_evt;

        // Re-fire from WAIT only on a fresh edge, not on a still-held pending bit.
        assign w_evt = |(w_rise & r_mode & r_ena);

        always_ff @(posedge fclk or posedge rst) begin
            if (rst) begin
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                zint_req <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_gen && w_any) begin
                            r_state  <= ST_ASSERT;
                            r_cnt    <= c_LOAD;
                            zint_req <= 1'b1;
                        end
                    end
                    ST_ASSERT: begin
                        if (!r_gen) begin
                            r_state  <= ST_IDLE;
                            zint_req <= 1'b0;
                        end else if (r_cnt == '0) begin
                            r_state  <= ST_WAIT;
                            zint_req <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    ST_WAIT: begin
                        if (!r_gen) begin
                            r_state <= ST_IDLE;
                        end else if (w_evt) begin
                            r_state  <= ST_ASSERT;
                            r_cnt    <= c_LOAD;
                            zint_req <= 1'b1;
                        end else if (!w_any) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        zint_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zint_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zint_ctrl
//  Description : Directed self-checking bench; one level-output instance and
//                one PULSE_LEN=5 instance, both with IRQ_POL = 4'b0010.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zint_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] l_irq = 4'b1101;
    logic       l_wr_en = 1'b0;
    logic [1:0] l_addr = 2'd0;
    logic [7:0] l_wrdata = 8'h00;
    logic [7:0] l_rddata;
    logic       l_int;
    logic       l_req;

    logic [3:0] p_irq = 4'b1101;
    logic       p_wr_en = 1'b0;
    logic [1:0] p_addr = 2'd0;
    logic [7:0] p_wrdata = 8'h00;
    logic [7:0] p_rddata;
    logic       p_int;
    logic       p_req;

    int n_pass  = 0;
    int n_total = 0;

    logic [11:0] hist;
    logic        any_req;

    always #5 clk = ~clk;

    zint_ctrl #(
        .NCH(4), .IRQ_POL(8'b0010), .SYNC_STAGES(2), .PULSE_LEN(0)
    ) u_lvl (
        .fclk(clk), .rst(rst), .irq_raw(l_irq), .wr_en(l_wr_en), .addr(l_addr),
        .wrdata(l_wrdata), .rddata(l_rddata), .internal_int(l_int), .zint_req(l_req)
    );

    zint_ctrl #(
        .NCH(4), .IRQ_POL(8'b0010), .SYNC_STAGES(2), .PULSE_LEN(5)
    ) u_pls (
        .fclk(clk), .rst(rst), .irq_raw(p_irq), .wr_en(p_wr_en), .addr(p_addr),
        .wrdata(p_wrdata), .rddata(p_rddata), .internal_int(p_int), .zint_req(p_req)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input bit pls, input logic [1:0] a, input logic [7:0] d);
        if (pls) begin p_wr_en = 1'b1; p_addr = a; p_wrdata = d; end
        else     begin l_wr_en = 1'b1; l_addr = a; l_wrdata = d; end
        tick();
        p_wr_en = 1'b0;
        l_wr_en = 1'b0;
    endtask

    task automatic rd(input bit pls, input logic [1:0] a, input logic [7:0] exp, input string tag);
        if (pls) p_addr = a;
        else     l_addr = a;
        #1;
        chk(tag, {8'h00, (pls ? p_rddata : l_rddata)}, {8'h00, exp});
    endtask

    task automatic grab_hist();
        for (int i = 0; i < 12; i++) begin
            tick();
            hist[i] = p_req;
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        ticks(3);
        for (int a = 0; a < 4; a++) rd(1'b0, 2'(a), 8'h00, "rst_lvl_reg");
        chk("rst_lvl_req", {15'd0, l_req}, 16'd0);
        chk("rst_lvl_int", {15'd0, l_int}, 16'd0);
        chk("rst_pls_req", {15'd0, p_req}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // ---------------- level mode, channel 1 active-high ----------------
        wr(1'b0, 2'd0, 8'h0F);
        wr(1'b0, 2'd3, 8'h01);
        l_irq[1] = 1'b1;
        ticks(3);
        chk("lvl_rise_early", {15'd0, l_req}, 16'd0);
        tick();
        chk("lvl_rise_4cyc", {15'd0, l_req}, 16'd1);
        chk("lvl_int", {15'd0, l_int}, 16'd1);
        rd(1'b0, 2'd3, 8'h91, "lvl_ctrl");
        l_irq[1] = 1'b0;
        ticks(3);
        chk("lvl_fall_early", {15'd0, l_req}, 16'd1);
        tick();
        chk("lvl_fall_4cyc", {15'd0, l_req}, 16'd0);

        // ---------------- edge mode, channel 0 active-low ----------------
        wr(1'b0, 2'd1, 8'h01);
        l_irq[0] = 1'b0;
        ticks(3);
        l_irq[0] = 1'b1;
        ticks(4);
        rd(1'b0, 2'd2, 8'h01, "edge_pend_held");
        chk("edge_req", {15'd0, l_req}, 16'd1);
        wr(1'b0, 2'd2, 8'h01);
        chk("edge_clr_same", {15'd0, l_req}, 16'd1);
        tick();
        chk("edge_clr_next", {15'd0, l_req}, 16'd0);
        rd(1'b0, 2'd2, 8'h00, "edge_pend_clr");

        // write-1 lands on the edge where the new rise sets pend
        ticks(2);
        l_irq[0] = 1'b0;
        ticks(2);
        wr(1'b0, 2'd2, 8'h01);
        rd(1'b0, 2'd2, 8'h01, "edge_set_wins");
        l_irq[0] = 1'b1;
        wr(1'b0, 2'd2, 8'h01);
        tick();

        // ---------------- priority and masking ----------------
        wr(1'b0, 2'd1, 8'h00);
        l_irq = 4'b0001;
        ticks(4);
        rd(1'b0, 2'd3, 8'hA1, "prio_ch2");
        wr(1'b0, 2'd0, 8'h08);
        rd(1'b0, 2'd3, 8'hB1, "prio_ch3");
        wr(1'b0, 2'd0, 8'h00);
        tick();
        chk("mask_int", {15'd0, l_int}, 16'd0);
        chk("mask_req", {15'd0, l_req}, 16'd0);
        rd(1'b0, 2'd2, 8'h0C, "mask_pend");

        // ---------------- pulse mode ----------------
        wr(1'b1, 2'd0, 8'h0F);
        wr(1'b1, 2'd3, 8'h01);
        wr(1'b1, 2'd1, 8'h01);
        p_irq[0] = 1'b0;
        grab_hist();
        chk("pulse_first", {4'd0, hist}, 16'h00F8);
        p_irq[0] = 1'b1;
        any_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            any_req = any_req | p_req;
        end
        chk("pulse_wait_quiet", {15'd0, any_req}, 16'd0);
        p_irq[0] = 1'b0;
        grab_hist();
        chk("pulse_refire", {4'd0, hist}, 16'h007C);
        wr(1'b1, 2'd2, 8'h01);
        ticks(2);
        chk("pulse_clr_req", {15'd0, p_req}, 16'd0);
        p_irq[0] = 1'b1;
        ticks(4);
        p_irq[0] = 1'b0;
        grab_hist();
        chk("pulse_from_idle", {4'd0, hist}, 16'h00F8);

        // ---------------- reset mid-pulse ----------------
        wr(1'b1, 2'd2, 8'h01);
        tick();
        p_irq[0] = 1'b1;
        ticks(4);
        wr(1'b1, 2'd1, 8'h0F);
        p_irq = 4'b0010;
        ticks(5);
        chk("rst_pre_req", {15'd0, p_req}, 16'd1);
        rd(1'b1, 2'd2, 8'h0F, "rst_pre_pend");
        rst = 1'b1;
        #1;
        chk("rst_async_req", {15'd0, p_req}, 16'd0);
        chk("rst_async_int", {15'd0, p_int}, 16'd0);
        for (int a = 0; a < 4; a++) rd(1'b1, 2'(a), 8'h00, "rst_async_reg");
        @(negedge clk);
        rst = 1'b0;
        any_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_req = any_req | p_req;
        end
        chk("rst_no_refire", {15'd0, any_req}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
